// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative, write-through, no-write-allocate
// data cache between the MEM stage and the SRAM controller. Loads that hit
// complete in the same cycle. Misses fetch a full 64-bit line. Every store
// is passed through to SRAM.
// Optional feature: define CACHE_STATS_EN to add hit_count/miss_count outputs.
module cache_controller #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned SETS      = 64,
    parameter int unsigned TAG_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_read,
    output logic        sram_write,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_LO = IDX_W + 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Address decomposition relative to the start of the cached region
    logic [31:0]       off;
    logic              word_sel;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic              unused_off_bits;

    assign off             = address - 32'(BASE_ADDR);
    assign word_sel        = off[2];
    assign index           = off[TAG_LO-1:3];
    assign tag             = off[TAG_LO+TAG_W-1:TAG_LO];
    assign unused_off_bits = ^{off[31:TAG_LO+TAG_W], off[1:0]};

    // Line storage: valid/lru need reset, tag/data do not
    logic [SETS-1:0]  valid_q [2];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [63:0]      data_q  [2][SETS];
    logic [SETS-1:0]  lru_q;

    // Tag lookup in both ways; the two ways never hold the same tag
    logic        hit0, hit1, hit, hit_way;
    logic [63:0] hit_line;
    logic [31:0] hit_word, fill_word;

    assign hit0      = valid_q[0][index] && (tag_q[0][index] == tag);
    assign hit1      = valid_q[1][index] && (tag_q[1][index] == tag);
    assign hit       = hit0 | hit1;
    assign hit_way   = hit1;
    assign hit_line  = data_q[hit_way][index];
    assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
    assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

    // Request classification; a store wins over a simultaneous load
    logic do_write, do_read_hit, do_read_miss, fill;

    assign do_write     = (state_q == IDLE) && mem_write;
    assign do_read_hit  = (state_q == IDLE) && !mem_write && mem_read && hit;
    assign do_read_miss = (state_q == IDLE) && !mem_write && mem_read && !hit;
    assign fill         = (state_q == READ_MISS) && sram_ready;

    // Victim choice: empty way0, then empty way1, then the LRU-named way
    logic victim_way;
    always_comb begin
        if (!valid_q[0][index])      victim_way = 1'b0;
        else if (!valid_q[1][index]) victim_way = 1'b1;
        else                         victim_way = lru_q[index];
    end

    // Line and LRU update requests for this cycle
    logic        line_we, line_way, lru_we, lru_val;
    logic [63:0] line_data;
    always_comb begin
        line_we   = 1'b0;
        line_way  = hit_way;
        line_data = hit_line;
        lru_we    = 1'b0;
        lru_val   = ~hit_way;
        if (fill) begin
            line_we   = 1'b1;
            line_way  = victim_way;
            line_data = sram_rdata;
            lru_we    = 1'b1;
            lru_val   = ~victim_way;
        end else if (do_write && hit) begin
            line_we = 1'b1;
            if (word_sel) line_data[63:32] = wdata;
            else          line_data[31:0]  = wdata;
            lru_we = 1'b1;
        end else if (do_read_hit) begin
            lru_we = 1'b1;
        end
    end

    // Valid bits and LRU bits, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            if (line_we) valid_q[line_way][index] <= 1'b1;
            if (lru_we)  lru_q[index]             <= lru_val;
        end
    end

    // Tag and data arrays; contents are meaningless until valid is set
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[line_way][index]  <= tag;
            data_q[line_way][index] <= line_data;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (do_write)          state_d = WRITE;
                else if (do_read_miss) state_d = READ_MISS;
            end
            READ_MISS, WRITE: begin
                if (sram_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; forced to their idle values while reset is held
    always_comb begin
        ready        = 1'b1;
        rdata        = 32'd0;
        sram_read    = 1'b0;
        sram_write   = 1'b0;
        sram_address = 32'd0;
        sram_wdata   = 32'd0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (mem_write) begin
                        ready = 1'b0;
                    end else if (mem_read) begin
                        ready = hit;
                        rdata = hit ? hit_word : 32'd0;
                    end
                end
                READ_MISS: begin
                    sram_read    = 1'b1;
                    sram_address = {address[31:3], 3'b000};
                    ready        = sram_ready;
                    rdata        = sram_ready ? fill_word : 32'd0;
                end
                WRITE: begin
                    sram_write   = 1'b1;
                    sram_address = address;
                    sram_wdata   = wdata;
                    ready        = sram_ready;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    // Count read hits and new misses accepted in IDLE; wrap naturally
    always_comb begin
        hit_count_d  = hit_count_q + (do_read_hit ? 32'd1 : 32'd0);
        miss_count_d = miss_count_q + (do_read_miss ? 32'd1 : 32'd0);
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: randomized bench for cache_controller. The bench acts
// as the SRAM controller and keeps a line-level memory image; because the
// cache is write-through, every load must return the memory image's word.
// A tag/LRU model predicts hit or miss and thus the stall pattern.
`timescale 1ns/1ps
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_read;
    logic        sram_write;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata = 64'd0;
    logic        sram_ready = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_read    (sram_read),
        .sram_write   (sram_write),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference state: memory image, tag/LRU model, statistics
    logic [63:0] mem_m [logic [28:0]];
    bit          mvalid [2][64];
    logic [9:0]  mtag   [2][64];
    bit          mlru   [64];
    int          exp_hits = 0;
    int          exp_misses = 0;

    // Per-cycle expectations consumed by the compare process
    logic        exp_valid = 1'b0;
    logic        exp_ready, exp_sram_read, exp_sram_write;
    logic [31:0] exp_rdata, exp_sram_address, exp_sram_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] get_line(input logic [31:0] a);
        logic [28:0] la;
        la = a[31:3];
        if (mem_m.exists(la)) return mem_m[la];
        return {32'h5A000000 ^ {3'b000, la}, 32'hC3000000 ^ {3'b000, ~la}};
    endfunction

    function automatic int model_lookup(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        for (int w = 0; w < 2; w++)
            if (mvalid[w][off[8:3]] && mtag[w][off[8:3]] == off[18:9]) return w;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 64; s++) begin
            mvalid[0][s] = 1'b0;
            mvalid[1][s] = 1'b0;
            mlru[s]      = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic set_exp(input logic r, input logic [31:0] rd, input logic sr,
                           input logic sw, input logic [31:0] sa, input logic [31:0] swd);
        exp_ready        = r;
        exp_rdata        = rd;
        exp_sram_read    = sr;
        exp_sram_write   = sw;
        exp_sram_address = sa;
        exp_sram_wdata   = swd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every cycle the expectations are armed
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("ready", 64'(ready), 64'(exp_ready));
            chk("rdata", 64'(rdata), 64'(exp_rdata));
            chk("sram_read", 64'(sram_read), 64'(exp_sram_read));
            chk("sram_write", 64'(sram_write), 64'(exp_sram_write));
            chk("sram_address", 64'(sram_address), 64'(exp_sram_address));
            chk("sram_wdata", 64'(sram_wdata), 64'(exp_sram_wdata));
`ifdef CACHE_STATS_EN
            chk("hit_count", 64'(hit_count), 64'(exp_hits));
            chk("miss_count", 64'(miss_count), 64'(exp_misses));
`endif
        end
    end

    task automatic do_idle();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        sram_ready = 1'($urandom_range(0, 1));
        sram_rdata = {$urandom, $urandom};
        set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();
        sram_ready = 1'b0;
        $display("[TB] idle cycle");
    endtask

    task automatic do_read(input logic [31:0] a, input int lat,
                           output logic hit_obs, output logic [31:0] data_obs);
        logic [31:0] off;
        logic [5:0]  idx;
        int          way;
        int          n;
        logic [63:0] line;
        logic [31:0] word;
        logic        v;
        off  = a - 32'd1024;
        idx  = off[8:3];
        way  = model_lookup(a);
        line = get_line(a);
        word = off[2] ? line[63:32] : line[31:0];
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        address    = a;
        wdata      = $urandom;
        sram_ready = 1'($urandom_range(0, 1));
        sram_rdata = {$urandom, $urandom};
        data_obs   = 32'd0;
        if (way >= 0) begin
            set_exp(1'b1, word, 1'b0, 1'b0, 32'd0, 32'd0);
            @(negedge clk);
            hit_obs  = ready;
            data_obs = rdata;
            @(posedge clk);
            mlru[idx] = (way == 0);
            exp_hits++;
            #1;
        end else begin
            set_exp(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
            @(negedge clk);
            hit_obs = ready;
            next_cycle();
            exp_misses++;
            n = (lat == 0) ? int'($urandom_range(1, 5)) : lat;
            for (int i = 0; i < n; i++) begin
                sram_ready = (i == n - 1);
                sram_rdata = sram_ready ? line : {$urandom, $urandom};
                set_exp(sram_ready, sram_ready ? word : 32'd0, 1'b1, 1'b0,
                        {a[31:3], 3'b000}, 32'd0);
                @(negedge clk);
                data_obs = rdata;
                @(posedge clk);
                if (i == n - 1) begin
                    if (!mvalid[0][idx])      v = 1'b0;
                    else if (!mvalid[1][idx]) v = 1'b1;
                    else                      v = mlru[idx];
                    mvalid[v][idx] = 1'b1;
                    mtag[v][idx]   = off[18:9];
                    mlru[idx]      = ~v;
                end
                #1;
            end
        end
        mem_read   = 1'b0;
        sram_ready = 1'b0;
        set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        $display("[TB] read  0x%08h %s rdata=0x%08h", a, (way >= 0) ? "hit " : "miss", data_obs);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat);
        logic [31:0] off;
        logic [5:0]  idx;
        int          way;
        int          n;
        logic [63:0] line;
        off  = a - 32'd1024;
        idx  = off[8:3];
        way  = model_lookup(a);
        line = get_line(a);
        if (off[2]) line[63:32] = d;
        else        line[31:0]  = d;
        mem_m[a[31:3]] = line;
        mem_write  = 1'b1;
        mem_read   = 1'($urandom_range(0, 1));
        address    = a;
        wdata      = d;
        sram_ready = 1'($urandom_range(0, 1));
        sram_rdata = {$urandom, $urandom};
        set_exp(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        if (way >= 0) mlru[idx] = (way == 0);
        #1;
        n = (lat == 0) ? int'($urandom_range(1, 5)) : lat;
        for (int i = 0; i < n; i++) begin
            sram_ready = (i == n - 1);
            sram_rdata = {$urandom, $urandom};
            set_exp(sram_ready, 32'd0, 1'b0, 1'b1, a, d);
            next_cycle();
        end
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        sram_ready = 1'b0;
        set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        $display("[TB] write 0x%08h data=0x%08h %s", a, d, (way >= 0) ? "hit" : "miss");
    endtask

    // Start a read that must miss, then reset while the fill is pending
    task automatic reset_mid(input logic [31:0] a);
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        address    = a;
        sram_ready = 1'b0;
        set_exp(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();
        exp_misses++;
        set_exp(1'b0, 32'd0, 1'b1, 1'b0, {a[31:3], 3'b000}, 32'd0);
        next_cycle();
        rst = 1'b1;
        model_clear();
        set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();
        rst      = 1'b0;
        mem_read = 1'b0;
        $display("[TB] reset during line fill of 0x%08h", a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        h;
        logic [31:0] d;
        logic [31:0] a;
        int          r;
        model_clear();
        set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        exp_valid = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        next_cycle();
        $display("[TB] reset released");

        // Directed scenarios with hand-computed results
        mem_m[29'h80] = 64'h11111111_22222222;
        do_read(32'h400, 4, h, d);
        chk("first_read_miss", 64'(h), 64'h0);
        chk("first_read_data", 64'(d), 64'h22222222);
        do_read(32'h404, 0, h, d);
        chk("reread_hit", 64'(h), 64'h1);
        chk("reread_data", 64'(d), 64'h11111111);
        do_read(32'h600, 0, h, d);
        chk("fill_600_miss", 64'(h), 64'h0);
        do_read(32'h400, 0, h, d);
        chk("hit_400", 64'(h), 64'h1);
        do_read(32'h800, 0, h, d);
        chk("miss_800", 64'(h), 64'h0);
        do_read(32'h400, 0, h, d);
        chk("hit_400_kept", 64'(h), 64'h1);
        do_read(32'h600, 0, h, d);
        chk("miss_600_evicted", 64'(h), 64'h0);
        do_write(32'h404, 32'hDEADBEEF, 3);
        do_read(32'h404, 0, h, d);
        chk("write_hit_reread", 64'(h), 64'h1);
        chk("write_hit_data", 64'(d), 64'hDEADBEEF);
        do_write(32'hA00, 32'h0BADF00D, 2);
        do_read(32'hA00, 0, h, d);
        chk("no_allocate_miss", 64'(h), 64'h0);
        chk("no_allocate_data", 64'(d), 64'h0BADF00D);
        reset_mid(32'hC00);
        do_read(32'hC00, 0, h, d);
        chk("post_reset_miss", 64'(h), 64'h0);

        // Randomized traffic over 4 sets x 4 tags to force conflicts
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            a = 32'd1024 + (32'($urandom_range(0, 3)) << 9)
                         + (32'($urandom_range(0, 3)) << 3)
                         + (32'($urandom_range(0, 1)) << 2);
            if (r < 45)                     do_read(a, 0, h, d);
            else if (r < 80)                do_write(a, $urandom, 0);
            else if (r < 97)                do_idle();
            else if (model_lookup(a) < 0)   reset_mid(a);
            else                            do_read(a, 0, h, d);
        end

        repeat (2) next_cycle();
        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
